// File: rtl/f32_pkg.sv
// f32_pkg: binary32 constants, flag bundle and
// accumulator state type shared across the slice.
package f32_pkg;
   localparam logic [31:0] F32_NEG_ZERO    = 32'h8000_0000;
   localparam logic [31:0] F32_POS_INF     = 32'h7F80_0000;
   localparam logic [31:0] F32_DEFAULT_NAN = 32'h7FC0_0000;

   typedef struct packed {
      logic invalid;
      logic overflow;
      logic underflow;
      logic inexact;
   } f32_flags_t;

   typedef enum logic {ACC, HOLD} acc_state_t;
endpackage

// File: rtl/f32_stream_accumulator_if.sv
// f32_stream_accumulator_if: operand stream in,
// packet result out, both valid/ready.
interface f32_stream_accumulator_if #(
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_sum;
   logic [CNT_W-1:0] out_count;
   logic             out_invalid;
   logic             out_overflow;
   logic             out_underflow;
   logic             out_inexact;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_count,
      input  out_invalid, out_overflow,
      input  out_underflow, out_inexact
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_count,
      output out_invalid, out_overflow,
      output out_underflow, out_inexact
   );
endinterface

// File: rtl/f32_adder.sv
// f32_adder: combinational binary32 add, RNE,
// tininess after rounding, any NaN -> default NaN.
module f32_adder
   import f32_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] c,
   output f32_flags_t  flags
);
   function automatic logic [4:0] lzc27(
      input logic [26:0] v
   );
      logic [4:0] z;
      z = 5'd27;
      for (int i = 0; i < 27; i++)
         if (v[i]) z = 5'(26 - i);
      return z;
   endfunction

   logic a_nan, b_nan, a_snan, b_snan;
   logic a_inf, b_inf, swap;
   logic [31:0] x, y;
   logic [9:0]  ex, ey, dd, e, ef;
   logic [23:0] mx, my;
   logic [4:0]  d, lz, k;
   logic [53:0] sh;
   logic [26:0] al, n;
   logic [27:0] s;
   logic [24:0] r;
   logic        g, rs, inc;

   assign a_nan  = (&a[30:23]) & (|a[22:0]);
   assign b_nan  = (&b[30:23]) & (|b[22:0]);
   assign a_snan = a_nan & ~a[22];
   assign b_snan = b_nan & ~b[22];
   assign a_inf  = (&a[30:23]) & ~(|a[22:0]);
   assign b_inf  = (&b[30:23]) & ~(|b[22:0]);
   assign swap   = b[30:0] > a[30:0];

   always_comb begin
      x  = swap ? b : a;
      y  = swap ? a : b;
      ex = {2'b00, (|x[30:23]) ? x[30:23] : 8'd1};
      ey = {2'b00, (|y[30:23]) ? y[30:23] : 8'd1};
      mx = {|x[30:23], x[22:0]};
      my = {|y[30:23], y[22:0]};
      dd = ex - ey;
      d  = (dd > 10'd27) ? 5'd27 : dd[4:0];
      // low half of the shift window folds into sticky
      sh = {my, 3'b000, 27'd0} >> d;
      al = {sh[53:28], sh[27] | (|sh[26:0])};
      if (x[31] ^ y[31])
         s = {1'b0, mx, 3'b000} - {1'b0, al};
      else
         s = {1'b0, mx, 3'b000} + {1'b0, al};
      lz = lzc27(s[26:0]);
      k  = 5'd0;
      if (s[27]) begin
         n = {s[27:2], s[1] | s[0]};
         e = ex + 10'd1;
      end else begin
         // never normalise below the subnormal exponent
         if ({5'd0, lz} > ex - 10'd1)
            k = 5'(ex - 10'd1);
         else
            k = lz;
         n = s[26:0] << k;
         e = ex - {5'd0, k};
      end
      g   = n[2];
      rs  = n[1] | n[0];
      inc = g & (rs | n[3]);
      r   = {1'b0, n[26:3]} + {24'd0, inc};
      ef  = r[24] ? e + 10'd1 : (r[23] ? e : 10'd0);

      flags           = '0;
      c               = {x[31], ef[7:0], r[22:0]};
      flags.inexact   = g | rs;
      flags.underflow = ~r[24] & ~r[23] & (g | rs);
      if (ef >= 10'd255) begin
         c              = {x[31], F32_POS_INF[30:0]};
         flags.overflow = 1'b1;
         flags.inexact  = 1'b1;
      end
      if (s == 28'd0) begin
         c     = {x[31] & y[31], 31'd0};
         flags = '0;
      end
      if (a_nan | b_nan) begin
         c             = F32_DEFAULT_NAN;
         flags         = '0;
         flags.invalid = a_snan | b_snan;
      end else if (a_inf & b_inf & (a[31] ^ b[31])) begin
         c             = F32_DEFAULT_NAN;
         flags         = '0;
         flags.invalid = 1'b1;
      end else if (a_inf) begin
         c     = a;
         flags = '0;
      end else if (b_inf) begin
         c     = b;
         flags = '0;
      end
   end
endmodule

// File: rtl/f32_stream_accumulator.sv
// f32_stream_accumulator: left-to-right packet sum
// with sticky flags and saturating element count.
module f32_stream_accumulator
   import f32_pkg::*;
#(
   parameter int CNT_W = 16
)(
   input  logic clk,
   input  logic rst_n,
   f32_stream_accumulator_if.slave io
);
   acc_state_t       state;
   logic [31:0]      acc, sum, osum;
   f32_flags_t       af, flg, oflg;
   logic [CNT_W-1:0] cnt, cnt_n, ocnt;
   logic             fire;

   f32_adder u_add (
      .a     (acc),
      .b     (io.in_data),
      .c     (sum),
      .flags (af)
   );

   assign fire  = io.in_valid & (state == ACC);
   assign cnt_n = (&cnt) ? cnt : cnt + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ACC;
         acc   <= F32_NEG_ZERO;
         flg   <= '0;
         cnt   <= '0;
         osum  <= '0;
         oflg  <= '0;
         ocnt  <= '0;
      end else begin
         unique case (state)
            ACC: if (fire) begin
               if (io.in_last) begin
                  osum  <= sum;
                  oflg  <= f32_flags_t'(flg | af);
                  ocnt  <= cnt_n;
                  acc   <= F32_NEG_ZERO;
                  flg   <= '0;
                  cnt   <= '0;
                  state <= HOLD;
               end else begin
                  acc <= sum;
                  flg <= f32_flags_t'(flg | af);
                  cnt <= cnt_n;
               end
            end
            HOLD: if (io.out_ready) state <= ACC;
         endcase
      end
   end

   assign io.in_ready      = (state == ACC);
   assign io.out_valid     = (state == HOLD);
   assign io.out_sum       = osum;
   assign io.out_count     = ocnt;
   assign io.out_invalid   = oflg.invalid;
   assign io.out_overflow  = oflg.overflow;
   assign io.out_underflow = oflg.underflow;
   assign io.out_inexact   = oflg.inexact;
endmodule

// File: tb/tb_f32_stream_accumulator.sv
// tb_f32_stream_accumulator: directed packets plus
// random streams against an exact-arithmetic model.
module tb_f32_stream_accumulator;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   typedef struct packed {
      logic [31:0] d;
      logic        l;
   } beat_t;

   typedef struct packed {
      logic [31:0]      sum;
      logic [CNT_W-1:0] cnt;
      logic [3:0]       fl;
   } exp_t;

   logic  clk;
   logic  rst_n;
   int    n_chk = 0;
   int    n_err = 0;
   beat_t bq[$];
   exp_t  eq[$];

   f32_stream_accumulator_if #(.CNT_W(CNT_W)) t ();

   f32_stream_accumulator #(.CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (t)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [63:0] obs,
                        input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [299:0] scale(input logic [31:0] v);
      logic [299:0] m;
      m = 300'(v[22:0]);
      if (v[30:23] != 8'd0) begin
         m[23] = 1'b1;
         m = m << (v[30:23] - 8'd1);
      end
      return m;
   endfunction

   // exact sum in units of 2^-149, then one RNE rounding
   function automatic void ref_add(input logic [31:0] a,
                                   input logic [31:0] b,
                                   output logic [31:0] c,
                                   output logic [3:0] f);
      logic [299:0] ma, mb, mag, q, rem, half, one;
      logic sg, an, bn, ai, bi, up;
      int p, sh, ex;
      one = 300'd1;
      an = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      ai = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      bi = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      f = 4'b0000;
      c = 32'h7FC00000;
      if (an || bn) begin
         f[3] = (an && !a[22]) || (bn && !b[22]);
         return;
      end
      if (ai && bi && (a[31] != b[31])) begin
         f[3] = 1'b1;
         return;
      end
      if (ai) begin c = a; return; end
      if (bi) begin c = b; return; end
      ma = scale(a);
      mb = scale(b);
      if (a[31] == b[31]) begin
         mag = ma + mb; sg = a[31];
      end else if (ma >= mb) begin
         mag = ma - mb; sg = a[31];
      end else begin
         mag = mb - ma; sg = b[31];
      end
      if (mag == 300'd0) begin
         c = {a[31] & b[31], 31'd0};
         return;
      end
      p = 0;
      for (int i = 0; i < 300; i++)
         if (mag[i]) p = i;
      if (p <= 23) begin
         c = {sg, mag[30:0]};
         return;
      end
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag & ((one << sh) - one);
      half = one << (sh - 1);
      up   = (rem > half) || ((rem == half) && q[0]);
      q    = q + 300'(up);
      if (q[24]) begin
         q = q >> 1;
         sh++;
      end
      ex = sh + 1;
      f[0] = (rem != 300'd0);
      if (ex >= 255) begin
         c = {sg, 8'hFF, 23'd0};
         f[2] = 1'b1;
         f[0] = 1'b1;
      end else begin
         c = {sg, 8'(ex), q[22:0]};
      end
   endfunction

   function automatic exp_t model_pkt(input logic [31:0] v[$]);
      exp_t e;
      logic [31:0] acc, r;
      logic [3:0]  f, fl;
      acc = 32'h80000000;
      fl  = 4'b0000;
      foreach (v[i]) begin
         ref_add(acc, v[i], r, f);
         acc = r;
         fl  = fl | f;
      end
      e.sum = acc;
      e.fl  = fl;
      e.cnt = (v.size() > CMAX) ? CNT_W'(CMAX)
                                : CNT_W'(v.size());
      return e;
   endfunction

   task automatic push_beats(input logic [31:0] v[$]);
      foreach (v[i]) bq.push_back({v[i], i == v.size() - 1});
   endtask

   task automatic push_exp(input logic [31:0] s,
                           input int c,
                           input logic [3:0] fl);
      exp_t e;
      e.sum = s;
      e.cnt = CNT_W'(c);
      e.fl  = fl;
      eq.push_back(e);
   endtask

   function automatic logic [31:0] rnd_f32(input bit tiny);
      logic [31:0] v;
      int k;
      v = $urandom;
      k = $urandom_range(0, 19);
      if (tiny) v[30:23] = 8'($urandom_range(0, 2));
      else if (k == 0) v[30:23] = 8'h00;
      else if (k == 1) v[30:0] = 31'd0;
      else if (k == 2) v[30:0] = 31'h7F800000;
      else if (k == 3) v[30:23] = 8'hFF;
      else if (k <= 5) v[30:23] = 8'($urandom_range(253, 254));
      else v[30:23] = 8'($urandom_range(124, 132));
      return v;
   endfunction

   function automatic logic [3:0] oflags();
      return {t.out_invalid, t.out_overflow,
              t.out_underflow, t.out_inexact};
   endfunction

   task automatic run(input int vp, input int rp);
      int   budget;
      logic ordy;
      exp_t e;
      budget = 5000;
      while ((bq.size() > 0 || eq.size() > 0) && budget > 0) begin
         budget--;
         check("ready_excl", t.in_ready & t.out_valid, 0);
         ordy = ($urandom_range(0, 99) < rp);
         t.out_ready = ordy;
         if (t.out_valid) begin
            if (eq.size() == 0) begin
               check("unexpected_out", t.out_valid, 0);
            end else if (ordy) begin
               e = eq.pop_front();
               check("sum", t.out_sum, e.sum);
               check("count", t.out_count, e.cnt);
               check("flags", oflags(), e.fl);
            end else begin
               check("hold_sum", t.out_sum, eq[0].sum);
               check("hold_flags", oflags(), eq[0].fl);
            end
         end
         if (bq.size() > 0 && $urandom_range(0, 99) < vp) begin
            t.in_valid = 1'b1;
            t.in_data  = bq[0].d;
            t.in_last  = bq[0].l;
            if (t.in_ready) void'(bq.pop_front());
         end else begin
            t.in_valid = 1'b0;
            t.in_data  = $urandom;
            t.in_last  = 1'($urandom);
         end
         tick();
      end
      check("run_drain", 64'(bq.size() + eq.size()), 0);
      t.in_valid  = 1'b0;
      t.out_ready = 1'b1;
   endtask

   task automatic send(input logic [31:0] d, input logic l);
      int n;
      t.in_valid = 1'b1;
      t.in_data  = d;
      t.in_last  = l;
      n = 0;
      while (!t.in_ready && n < 50) begin
         tick();
         n++;
      end
      check("send_ready", t.in_ready, 1);
      tick();
      t.in_valid = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_in_ready"}, t.in_ready, 1);
      check({tag, "_out_valid"}, t.out_valid, 0);
      check({tag, "_sum"}, t.out_sum, 0);
      check({tag, "_count"}, t.out_count, 0);
      check({tag, "_flags"}, oflags(), 0);
   endtask

   initial begin
      logic [31:0] pk[$];
      rst_n       = 1'b0;
      t.in_valid  = 1'b0;
      t.in_data   = 32'd0;
      t.in_last   = 1'b0;
      t.out_ready = 1'b1;
      repeat (2) tick();
      check_reset("rst");
      rst_n = 1'b1;
      tick();

      pk = {32'h3F800000, 32'h40000000, 32'h40400000};
      push_beats(pk); push_exp(32'h40C00000, 3, 4'b0000);
      pk = {32'h80000000};
      push_beats(pk); push_exp(32'h80000000, 1, 4'b0000);
      pk = {32'h7F7FFFFF, 32'h7F7FFFFF};
      push_beats(pk); push_exp(32'h7F800000, 2, 4'b0101);
      pk = {32'h7F800000, 32'hFF800000, 32'h3F800000};
      push_beats(pk); push_exp(32'h7FC00000, 3, 4'b1000);
      run(100, 100);

      pk = {};
      for (int i = 0; i < 15; i++) pk.push_back(32'h3F800000);
      push_beats(pk); push_exp(32'h41700000, 15, 4'b0000);
      for (int i = 0; i < 5; i++) pk.push_back(32'h3F800000);
      push_beats(pk); push_exp(32'h41A00000, CMAX, 4'b0000);
      run(100, 100);

      t.out_ready = 1'b0;
      send(32'h3F800000, 1'b0);
      send(32'h30800000, 1'b1);
      t.in_valid = 1'b1;
      t.in_data  = 32'h40000000;
      t.in_last  = 1'b1;
      check("t5_valid", t.out_valid, 1);
      for (int i = 0; i < 3; i++) begin
         check("t5_sum", t.out_sum, 32'h3F800000);
         check("t5_flags", oflags(), 4'b0001);
         check("t5_count", t.out_count, 2);
         check("t5_in_ready", t.in_ready, 0);
         tick();
      end
      t.out_ready = 1'b1;
      check("t5_bubble", t.in_ready, 0);
      tick();
      t.in_valid = 1'b0;
      check("t5_released", t.out_valid, 0);
      check("t5_ready_again", t.in_ready, 1);
      pk = {32'h3F800000};
      push_beats(pk); push_exp(32'h3F800000, 1, 4'b0000);
      run(100, 100);

      send(32'h40000000, 1'b0);
      send(32'h7F7FFFFF, 1'b0);
      rst_n = 1'b0;
      tick();
      check_reset("t6");
      rst_n = 1'b1;
      pk = {32'h40000000};
      push_beats(pk); push_exp(32'h40000000, 1, 4'b0000);
      run(100, 100);

      for (int p = 0; p < 80; p++) begin
         int  len;
         bit  tiny;
         len  = (p % 10 == 9) ? $urandom_range(13, 18)
                              : $urandom_range(1, 6);
         tiny = ($urandom_range(0, 4) == 0);
         pk = {};
         for (int i = 0; i < len; i++) pk.push_back(rnd_f32(tiny));
         push_beats(pk);
         eq.push_back(model_pkt(pk));
      end
      run(70, 60);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
